// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests, with a bounded data-run counter
// so a continuously busy load/store unit cannot starve instruction fetch.
module mem_arb_pick #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic pick_d,
  output logic pick_valid
);

  localparam int CW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DATA_RUN);

  logic [CW-1:0] run_cnt_q;
  logic [CW-1:0] run_cnt_d;

  always_comb begin
    pick_valid = if_req | d_req;
    pick_d     = d_req && (!if_req || (run_cnt_q < RUN_MAX));
    run_cnt_d  = run_cnt_q;
    // The counter only moves on an actual grant; it never exceeds RUN_MAX because
    // data stops winning against a pending fetch once the limit is reached.
    if (grant_en && pick_valid) begin
      if (pick_d && if_req) begin
        run_cnt_d = run_cnt_q + CW'(1);
      end else begin
        run_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-ported memory,
// one outstanding transaction at a time (IDLE -> ISSUE -> WAIT).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0]   mem_be_q, mem_be_d;
  logic              grant_en;
  logic              pick_d;
  logic              pick_valid;

  mem_arb_pick #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .d_req     (d_req),
    .grant_en  (grant_en),
    .pick_d    (pick_d),
    .pick_valid(pick_valid)
  );

  // Handshake: a requester holds req and fields until its gnt pulse (issued only in
  // IDLE); memory accepts in ISSUE via mem_gnt and answers in WAIT via mem_rvalid.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    if_rdata    = '0;
    d_rdata     = '0;
    grant_en    = (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = ISSUE;
          mem_req_d = 1'b1;
          if (pick_d) begin
            // Gated by rst so a request held during reset never sees a grant.
            d_gnt       = rst;
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end else begin
            if_gnt      = rst;
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, priority/run limit, async reset, and
// a spurious memory response.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            if_req = 1'b0;
  logic [AW-1:0]   if_addr = '0;
  logic            if_gnt, if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [AW-1:0]   d_addr = '0;
  logic [DW-1:0]   d_wdata = '0;
  logic [DW/8-1:0] d_be = '0;
  logic            d_gnt, d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_gnt = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            busy;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Checking
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitors: response pulse counts, protocol-violation count, field stability
  int            if_rv_cnt = 0;
  int            d_rv_cnt  = 0;
  int            viol_cnt  = 0;
  int            issue_cycles = 0;
  logic          fld_en = 1'b0;
  logic          fld_we = 1'b0;
  logic [AW-1:0] fld_addr = '0;
  logic [DW-1:0] fld_wdata = '0;
  logic [3:0]    fld_be = '0;

  always @(negedge clk) begin
    if (rst && if_rvalid) if_rv_cnt++;
    if (rst && d_rvalid) d_rv_cnt++;
    // mem_rvalid is only legal in WAIT (busy with no request outstanding)
    if (rst && mem_rvalid && !(busy && !mem_req)) viol_cnt++;
    if (fld_en && mem_req) begin
      issue_cycles++;
      chk("fld_addr", mem_addr, fld_addr);
      chk("fld_we", mem_we, fld_we);
      if (fld_we) begin
        chk("fld_wdata", mem_wdata, fld_wdata);
        chk("fld_be", mem_be, fld_be);
      end
    end
  end

  // Driver: one full transaction, entered just after the edge that starts an IDLE cycle
  task automatic txn(input int wait_cycles, input logic [DW-1:0] rd,
                     output logic got_if, output logic got_d,
                     output logic rv_if, output logic rv_d, output logic [DW-1:0] rdat);
    @(negedge clk);
    got_if = if_gnt;
    got_d  = d_gnt;
    chk("mem_req_cycle0", mem_req, 1'b0);
    @(posedge clk); #1;
    repeat (wait_cycles) begin
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    rv_if = if_rvalid;
    rv_d  = d_rvalid;
    rdat  = rv_if ? if_rdata : d_rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  logic          gi, gd, ri, rdv;
  logic [DW-1:0] rdat;
  logic          exp_d;
  int            d_rv_before;
  int            viol_before;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_run_cnt", dut.u_pick.run_cnt_q, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single fetch
    if_req = 1'b1; if_addr = 32'h0000_0010;
    fld_en = 1'b1; fld_we = 1'b0; fld_addr = 32'h0000_0010; issue_cycles = 0;
    txn(0, 32'h00A0_0093, gi, gd, ri, rdv, rdat);
    if_req = 1'b0; fld_en = 1'b0;
    chk("fetch_if_gnt", gi, 1'b1);
    chk("fetch_d_gnt", gd, 1'b0);
    chk("fetch_if_rvalid", ri, 1'b1);
    chk("fetch_d_rvalid", rdv, 1'b0);
    chk("fetch_rdata", rdat, 32'h00A0_0093);
    chk("fetch_issue_cycles", issue_cycles, 1);
    chk("fetch_if_rv_cnt", if_rv_cnt, 1);
    chk("fetch_d_rv_cnt", d_rv_cnt, 0);
    @(negedge clk);
    chk("fetch_idle_busy", busy, 1'b0);
    chk("fetch_idle_if_gnt", if_gnt, 1'b0);

    // Store with memory stalling mem_gnt for 3 cycles
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    fld_en = 1'b1; fld_we = 1'b1; fld_addr = 32'h0000_0100; fld_wdata = 32'hDEAD_BEEF;
    fld_be = 4'hF; issue_cycles = 0; d_rv_cnt = 0;
    txn(3, 32'h0, gi, gd, ri, rdv, rdat);
    d_req = 1'b0; fld_en = 1'b0;
    chk("store_d_gnt", gd, 1'b1);
    chk("store_d_rvalid", rdv, 1'b1);
    chk("store_issue_cycles", issue_cycles, 4);
    chk("store_d_rv_cnt", d_rv_cnt, 1);

    // Both requests held high: D,D,D,D,IF repeating
    d_we = 1'b0; d_addr = 32'h0000_0200; if_addr = 32'h0000_0020;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_d = (i % 5) != 4;
      txn(0, DW'(i + 1), gi, gd, ri, rdv, rdat);
      chk($sformatf("order%0d_d_gnt", i), gd, exp_d);
      chk($sformatf("order%0d_if_gnt", i), gi, !exp_d);
      chk($sformatf("order%0d_rdata", i), rdat, i + 1);
    end

    // Build up run_cnt, then data-only grants must clear it
    for (int i = 0; i < 2; i++) txn(0, 32'h0, gi, gd, ri, rdv, rdat);
    if_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      txn(0, 32'h0, gi, gd, ri, rdv, rdat);
      chk($sformatf("dataonly%0d_d_gnt", i), gd, 1'b1);
    end
    chk("dataonly_run_cnt", dut.u_pick.run_cnt_q, 0);
    if_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_d = (i != 4);
      txn(0, 32'h0, gi, gd, ri, rdv, rdat);
      chk($sformatf("after_clear%0d_d_gnt", i), gd, exp_d);
    end

    // Three data grants (run_cnt=3), a fourth reaches WAIT, then async reset
    for (int i = 0; i < 3; i++) txn(0, 32'h0, gi, gd, ri, rdv, rdat);
    @(negedge clk);
    chk("pre_rst_d_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
    d_rv_before = d_rv_cnt;
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ctl", {mem_req, mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, busy}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_no_d_rvalid", d_rv_cnt, d_rv_before);
    txn(0, 32'h0000_0077, gi, gd, ri, rdv, rdat);
    d_req = 1'b0;
    chk("post_rst_d_gnt", gd, 1'b1);
    chk("post_rst_if_gnt", gi, 1'b0);
    chk("post_rst_rdata", rdat, 32'h0000_0077);

    // Spurious mem_rvalid while in ISSUE
    viol_before = viol_cnt;
    @(negedge clk);
    chk("spur_if_gnt", if_gnt, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    chk("spur_rvalid", {if_rvalid, d_rvalid}, 0);
    chk("spur_mem_req", mem_req, 1'b1);
    chk("spur_busy", busy, 1'b1);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("spur_still_issue", mem_req, 1'b1);
    chk("spur_violation", viol_cnt, viol_before + 1);
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
    @(negedge clk);
    chk("spur_final_if_rvalid", if_rvalid, 1'b1);
    chk("spur_final_if_rdata", if_rdata, 32'h0000_1234);
    chk("spur_final_d_rdata", d_rdata, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("spur_end_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the core's instruction-fetch port and its load/store port, replacing the separate Imem/Dmem paths. It is a three-state controller that serialises accesses one at a time, with exactly one transaction outstanding. Data accesses have priority, and a bounded-run counter prevents fetch starvation. It sits between the core's PC/fetch logic plus load/store unit and the memory macro. The core stalls while its port is not yet served.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_DATA_RUN`, 4, consecutive data grants allowed while fetch is pending (≥1)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch request
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch request accepted (1-cycle pulse)
- `if_rvalid`  out  1  fetch data valid (1-cycle pulse)
- `if_rdata`  out  DW  fetch data
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_be`  in  DW/8  byte enables
- `d_gnt`  out  1  data request accepted (1-cycle pulse)
- `d_rvalid`  out  1  load data valid, or store completion (1-cycle pulse)
- `d_rdata`  out  DW  load data
- `mem_req`  out  1  memory request
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/AW/DW/DW/8  latched request fields
- `mem_gnt`  in  1  memory accepted request
- `mem_rvalid`  in  1  memory response (issued for reads and writes)
- `mem_rdata`  in  DW  memory read data
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is present, pick a winner, pulse its `*_gnt` combinationally in this cycle, latch its fields into the `mem_*` registers, record the owner, and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: `mem_req`=1 with stable fields. On `mem_gnt`, go to WAIT. Otherwise hold.
- WAIT: `mem_req`=0. On `mem_rvalid`, pulse the owner's `*_rvalid`, pass `mem_rdata` to the owner's `*_rdata`, and go to IDLE.
- `*_rdata` is `mem_rdata` while the matching `*_rvalid` is 1, else 0.
- Winner selection in IDLE:
  - Data wins if `d_req` and (`!if_req` or `run_cnt < MAX_DATA_RUN`).
  - Otherwise fetch wins.
- `run_cnt` (width clog2(MAX_DATA_RUN+1)), updated only on a grant:
  - Data grant with `if_req`=1: increment.
  - Data grant with `if_req`=0: clear to 0.
  - Fetch grant: clear to 0.
- Requesters hold `req` and fields stable until `gnt`. They may drop `req` after `gnt`, or withdraw before it at no cost. The fields are not sampled again after `gnt`.
- `mem_rvalid` in IDLE or ISSUE is ignored; it is a protocol violation, and a bench assertion flags it.
- `mem_gnt` outside ISSUE is ignored.
- Reset, at any time including mid-transaction:
  - State goes to IDLE, `run_cnt`=0, and the outstanding transaction is dropped.
  - All outputs go to 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, both `gnt`, both `rvalid`, both `rdata`, `busy`.
  - The memory is reset together with the arbiter.

## Timing
- Request seen at cycle 0 in IDLE: `gnt` in cycle 0, `mem_req` cycles 1..k, where k is the first cycle with `mem_gnt`=1.
- Owner `rvalid` comes in the same cycle as `mem_rvalid`, at the earliest cycle k+1. IDLE follows on the next cycle.
- Minimum 3 cycles per transaction; back-to-back throughput is one transaction per 3 cycles at zero memory latency.
- No combinational path from `mem_gnt` to any `mem_*` output.
- Combinational paths:
  - `mem_rvalid`/`mem_rdata` → `*_rvalid`/`*_rdata`.
  - `if_req`/`d_req` → `*_gnt` (IDLE only).

## Structure
- Shared package `mem_arb_pkg`: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2) and owner encoding (OWN_IF=1'b0, OWN_D=1'b1).
- Sub-module `mem_arb_pick`: combinational winner selection plus the `run_cnt` register. Inputs: `if_req`, `d_req`, `grant_en`. Outputs: `pick_d`, `pick_valid`.
- The top contains the FSM, the field/owner registers and the response steering.

## Test plan
- Single fetch: `if_req`, `if_addr`=0x0000_0010, mem returns 0x00A0_0093 with `mem_gnt` at cycle 1 and `mem_rvalid` at cycle 2 → `if_gnt` at cycle 0, `if_rvalid`=1 and `if_rdata`=0x00A0_0093 at cycle 2, `d_rvalid` never asserted.
- Store: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF, `d_be`=4'b1111, memory holds `mem_gnt` low for 3 cycles → `mem_*` fields stable over all 4 ISSUE cycles, one `d_rvalid` pulse.
- Simultaneous requests with `if_req` held high and `d_req` held high, MAX_DATA_RUN=4 → grant order D,D,D,D,IF,D,D,D,D,IF.
- Data request while fetch idle: 10 consecutive data grants with `if_req`=0 → `run_cnt` stays 0; then both requests arrive → data wins.
- Reset asserted in WAIT with `mem_rvalid` pending → all outputs 0 immediately (asynchronous); after release, state is IDLE and the first grant goes to the priority winner.
- Spurious `mem_rvalid` in ISSUE → no `*_rvalid` pulse, state unchanged, assertion fires.
